suit_match_scheduler: RTL and testbench

Sequences suit classification for one card corner: accepts a corner location from the card locator, arms a shared XOR suit scorer to capture the mask window on the next frame, then runs the scorer once per suit kernel. Tracks the lowest and second-lowest mismatch score and reports the best suit, its score, the confidence margin and a reject flag. Sits between the card locator and the XOR scorer datapath, and owns its start/kernel-select sequencing.

---
 rtl/suit_match_pkg.sv | 28 ++
 rtl/suit_match_scheduler_tracker.sv | 42 ++++
 rtl/suit_match_scheduler.sv | 167 ++++++++++++++++
 tb/tb_suit_match_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/suit_match_pkg.sv
// Shared types and corner-geometry constants for suit classification.
// Also used by the rank matcher, so the geometry lives here rather than in the scheduler.
package suit_match_pkg;

  localparam int CORNER_WIDTH = 28;
  localparam int RANK_HEIGHT  = 40;
  localparam int SUIT_HEIGHT  = 29;
  localparam int SUIT_SIZE    = CORNER_WIDTH * SUIT_HEIGHT;
  localparam int SW           = $clog2(SUIT_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_CAPTURE,
    ST_START,
    ST_WAIT_SCORE,
    ST_COMPARE,
    ST_RESULT
  } state_t;

  typedef enum logic [1:0] {
    SPADE   = 2'd0,
    HEART   = 2'd1,
    DIAMOND = 2'd2,
    CLUB    = 2'd3
  } suit_t;

endpackage

// File: rtl/suit_match_scheduler_tracker.sv
// Keeps the lowest and second-lowest score seen since the last clear, plus the index of the lowest.
// A score equal to the current best never displaces it, so ties favour the earlier index.
module best_two_tracker #(
  parameter int SW = 10,
  parameter int IW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_update,
  input  logic [SW-1:0] i_score,
  input  logic [IW-1:0] i_idx,
  output logic [SW-1:0] o_best,
  output logic [SW-1:0] o_second,
  output logic [IW-1:0] o_best_idx
);

  logic [SW-1:0] r_best;
  logic [SW-1:0] r_second;
  logic [IW-1:0] r_best_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_best     <= '1;
      r_second   <= '1;
      r_best_idx <= '0;
    end else if (i_update) begin
      if (i_score < r_best) begin
        r_second   <= r_best;
        r_best     <= i_score;
        r_best_idx <= i_idx;
      end else if (i_score < r_second) begin
        r_second <= i_score;
      end
    end
  end

  assign o_best     = r_best;
  assign o_second   = r_second;
  assign o_best_idx = r_best_idx;

endmodule

// File: rtl/suit_match_scheduler.sv
// Sequences one corner's suit classification: arm the XOR scorer for a full-frame capture,
// run one compare pass per suit kernel, and report best suit, score, margin and reject.
module suit_match_scheduler
  import suit_match_pkg::*;
#(
  parameter int corner_width  = CORNER_WIDTH,
  parameter int rank_height   = RANK_HEIGHT,
  parameter int suit_height   = SUIT_HEIGHT,
  parameter int NUM_SUITS     = 4,
  parameter int REJECT_THRESH = 200,
  parameter int SCORE_TIMEOUT = 1024,
  localparam int SCORE_W      = $clog2(corner_width * suit_height),
  localparam int KW           = (NUM_SUITS > 1) ? $clog2(NUM_SUITS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [10:0]        i_hcount,
  input  logic [9:0]         i_vcount,
  input  logic               i_req_valid,
  input  logic [10:0]        i_req_left_edge,
  input  logic [9:0]         i_req_top_edge,
  output logic               o_req_ready,
  output logic [10:0]        o_scr_left_edge,
  output logic [9:0]         o_scr_top_edge,
  output logic               o_scr_capture_arm,
  input  logic               i_scr_captured,
  output logic               o_scr_start,
  output logic [KW-1:0]      o_scr_kernel_sel,
  input  logic               i_scr_done,
  input  logic [SCORE_W-1:0] i_scr_score,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [KW-1:0]      o_res_suit,
  output logic [SCORE_W-1:0] o_res_score,
  output logic [SCORE_W-1:0] o_res_margin,
  output logic               o_res_reject,
  output logic               o_err_timeout
);

  localparam int TW = $clog2(SCORE_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [10:0]          r_left_edge;
  logic [9:0]           r_top_edge;
  logic [KW-1:0]        r_k;
  logic [1:0]           r_frame_cnt;
  logic [TW-1:0]        r_wait_cnt;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_err;

  logic                 w_frame_start;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_last_kernel;
  logic [SCORE_W-1:0]   w_best;
  logic [SCORE_W-1:0]   w_second;
  logic [KW-1:0]        w_best_idx;

  assign w_frame_start = (i_hcount == 11'd0) && (i_vcount == 10'd0);
  assign w_last_kernel = (r_k == KW'(NUM_SUITS - 1));

  // Both abort paths (missed capture, stalled scorer) land in RESULT with the error latched.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (w_frame_start) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (i_scr_captured) begin
          w_state_next = ST_START;
        end else if (w_frame_start && (r_frame_cnt == 2'd1)) begin
          w_abort      = 1'b1;
          w_state_next = ST_RESULT;
        end
      end
      ST_START: begin
        w_state_next = ST_WAIT_SCORE;
      end
      ST_WAIT_SCORE: begin
        if (i_scr_done) begin
          w_state_next = ST_COMPARE;
        end else if (r_wait_cnt == TW'(SCORE_TIMEOUT - 1)) begin
          w_abort      = 1'b1;
          w_state_next = ST_RESULT;
        end
      end
      ST_COMPARE: begin
        w_state_next = w_last_kernel ? ST_RESULT : ST_START;
      end
      ST_RESULT: begin
        if (i_res_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_left_edge <= '0;
      r_top_edge  <= '0;
      r_k         <= '0;
      r_frame_cnt <= '0;
      r_wait_cnt  <= '0;
      r_score     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_left_edge <= i_req_left_edge;
        r_top_edge  <= i_req_top_edge;
        r_k         <= '0;
        r_frame_cnt <= '0;
        r_err       <= 1'b0;
      end
      // The frame start that opens CAPTURE counts as the first; another one means a missed window.
      if ((r_state == ST_WAIT_FRAME) && w_frame_start) r_frame_cnt <= 2'd1;
      if ((r_state == ST_CAPTURE) && w_frame_start) r_frame_cnt <= r_frame_cnt + 2'd1;
      if (r_state == ST_START) r_wait_cnt <= '0;
      else if (r_state == ST_WAIT_SCORE) r_wait_cnt <= r_wait_cnt + TW'(1);
      if ((r_state == ST_WAIT_SCORE) && i_scr_done) r_score <= i_scr_score;
      if ((r_state == ST_COMPARE) && !w_last_kernel) r_k <= r_k + KW'(1);
      if (w_abort) r_err <= 1'b1;
    end
  end

  best_two_tracker #(
    .SW (SCORE_W),
    .IW (KW)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_accept),
    .i_update   (r_state == ST_COMPARE),
    .i_score    (r_score),
    .i_idx      (r_k),
    .o_best     (w_best),
    .o_second   (w_second),
    .o_best_idx (w_best_idx)
  );

  assign o_req_ready       = (r_state == ST_IDLE);
  assign o_scr_left_edge   = r_left_edge;
  assign o_scr_top_edge    = r_top_edge;
  assign o_scr_capture_arm = (r_state == ST_CAPTURE);
  assign o_scr_start       = (r_state == ST_START);
  assign o_scr_kernel_sel  = r_k;
  assign o_res_valid       = (r_state == ST_RESULT);

  // Result fields come straight from held registers and read as zero outside RESULT.
  assign o_res_suit    = o_res_valid ? w_best_idx : '0;
  assign o_res_score   = o_res_valid ? w_best : '0;
  assign o_res_margin  = o_res_valid ? (w_second - w_best) : '0;
  assign o_res_reject  = o_res_valid && ((int'(w_best) > REJECT_THRESH) || r_err);
  assign o_err_timeout = o_res_valid && r_err;

endmodule

// File: tb/tb_suit_match_scheduler.sv
// Directed self-checking bench for suit_match_scheduler with a hand-driven scorer model.
module tb_suit_match_scheduler;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        req_valid;
  logic [10:0] req_left_edge;
  logic [9:0]  req_top_edge;
  logic        req_ready;
  logic [10:0] scr_left_edge;
  logic [9:0]  scr_top_edge;
  logic        scr_capture_arm;
  logic        scr_captured;
  logic        scr_start;
  logic [1:0]  scr_kernel_sel;
  logic        scr_done;
  logic [9:0]  scr_score;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_suit;
  logic [9:0]  res_score;
  logic [9:0]  res_margin;
  logic        res_reject;
  logic        err_timeout;

  int vectors;
  int miscompares;

  suit_match_scheduler dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_hcount          (hcount),
    .i_vcount          (vcount),
    .i_req_valid       (req_valid),
    .i_req_left_edge   (req_left_edge),
    .i_req_top_edge    (req_top_edge),
    .o_req_ready       (req_ready),
    .o_scr_left_edge   (scr_left_edge),
    .o_scr_top_edge    (scr_top_edge),
    .o_scr_capture_arm (scr_capture_arm),
    .i_scr_captured    (scr_captured),
    .o_scr_start       (scr_start),
    .o_scr_kernel_sel  (scr_kernel_sel),
    .i_scr_done        (scr_done),
    .i_scr_score       (scr_score),
    .o_res_valid       (res_valid),
    .i_res_ready       (res_ready),
    .o_res_suit        (res_suit),
    .o_res_score       (res_score),
    .o_res_margin      (res_margin),
    .o_res_reject      (res_reject),
    .o_err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_req(input logic [10:0] l, input logic [9:0] t);
    req_left_edge = l;
    req_top_edge  = t;
    req_valid     = 1'b1;
    @(negedge clk);
    req_valid     = 1'b0;
  endtask

  task automatic frame_start();
    hcount = 11'd0;
    vcount = 10'd0;
    @(negedge clk);
    hcount = 11'd5;
    vcount = 10'd5;
  endtask

  task automatic pulse_captured();
    scr_captured = 1'b1;
    @(negedge clk);
    scr_captured = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (scr_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_res(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < limit) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Runs a full job; returns at the COMPARE cycle that follows the last scr_done.
  task automatic run_job(input logic [10:0] l, input logic [9:0] t, input logic [3:0][9:0] sc,
                         output bit ok, output bit ksel_ok);
    bit got;
    ok = 1'b1;
    ksel_ok = 1'b1;
    send_req(l, t);
    repeat (2) @(negedge clk);
    frame_start();
    repeat (3) @(negedge clk);
    pulse_captured();
    for (int k = 0; k < 4; k++) begin
      wait_start(got);
      if (!got) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      repeat (3) @(negedge clk);
      if (scr_kernel_sel != 2'(k)) ksel_ok = 1'b0;
      scr_score = sc[k];
      scr_done  = 1'b1;
      @(negedge clk);
      scr_done  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid got %b want 0", res_valid); end
    vectors++; if (scr_capture_arm !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_arm got %b want 0", scr_capture_arm); end
    vectors++; if (scr_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start got %b want 0", scr_start); end
    vectors++; if (res_score !== 10'd0 || res_margin !== 10'd0 || res_suit !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_res_fields got %0d/%0d/%0d want 0/0/0", res_score, res_margin, res_suit); end
    vectors++; if (res_reject !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags got %b%b want 00", res_reject, err_timeout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok, kok;
    run_job(11'd100, 10'd50, {10'd300, 10'd640, 10'd120, 10'd500}, ok, kok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_starts got %b want 1", ok); end
    vectors++; if (kok !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_kernel_sel got %b want 1", kok); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_valid_early got %b want 0", res_valid); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid_latency got %b want 1", res_valid); end
    vectors++; if (res_suit !== 2'd1) begin miscompares++; $display("[TB] FAIL basic_suit got %0d want 1", res_suit); end
    vectors++; if (res_score !== 10'd120) begin miscompares++; $display("[TB] FAIL basic_score got %0d want 120", res_score); end
    vectors++; if (res_margin !== 10'd180) begin miscompares++; $display("[TB] FAIL basic_margin got %0d want 180", res_margin); end
    vectors++; if (res_reject !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_flags got %b%b want 00", res_reject, err_timeout); end
    vectors++; if (scr_left_edge !== 11'd100 || scr_top_edge !== 10'd50) begin miscompares++; $display("[TB] FAIL basic_edges got %0d,%0d want 100,50", scr_left_edge, scr_top_edge); end
    release_result();
    vectors++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_release got ready=%b valid=%b want 1,0", req_ready, res_valid); end
  endtask

  task automatic test_tie();
    bit ok, kok;
    scr_done = 1'b1;
    scr_captured = 1'b1;
    @(negedge clk);
    scr_done = 1'b0;
    scr_captured = 1'b0;
    vectors++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL spurious_pulses got ready=%b valid=%b want 1,0", req_ready, res_valid); end
    run_job(11'd20, 10'd30, {10'd400, 10'd400, 10'd90, 10'd90}, ok, kok);
    @(negedge clk);
    vectors++; if (ok !== 1'b1 || res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_done got ok=%b valid=%b want 1,1", ok, res_valid); end
    vectors++; if (res_suit !== 2'd0) begin miscompares++; $display("[TB] FAIL tie_suit got %0d want 0", res_suit); end
    vectors++; if (res_score !== 10'd90) begin miscompares++; $display("[TB] FAIL tie_score got %0d want 90", res_score); end
    vectors++; if (res_margin !== 10'd0) begin miscompares++; $display("[TB] FAIL tie_margin got %0d want 0", res_margin); end
    vectors++; if (res_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_reject got %b want 0", res_reject); end
    release_result();
  endtask

  task automatic test_all_equal();
    bit ok, kok;
    run_job(11'd40, 10'd60, {10'd250, 10'd250, 10'd250, 10'd250}, ok, kok);
    @(negedge clk);
    vectors++; if (ok !== 1'b1 || res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL equal_done got ok=%b valid=%b want 1,1", ok, res_valid); end
    vectors++; if (res_reject !== 1'b1) begin miscompares++; $display("[TB] FAIL equal_reject got %b want 1", res_reject); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL equal_err got %b want 0", err_timeout); end
    vectors++; if (res_suit !== 2'd0 || res_margin !== 10'd0 || res_score !== 10'd250) begin miscompares++; $display("[TB] FAIL equal_fields got suit=%0d margin=%0d score=%0d want 0,0,250", res_suit, res_margin, res_score); end
    release_result();
  endtask

  task automatic test_score_timeout();
    bit ok, kok;
    int cyc;
    send_req(11'd7, 10'd8);
    @(negedge clk);
    frame_start();
    pulse_captured();
    wait_start(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL sto_start got %b want 1", ok); end
    wait_res(1100, ok, cyc);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL sto_result_seen got %b want 1", ok); end
    vectors++; if (cyc < 1024 || cyc > 1026) begin miscompares++; $display("[TB] FAIL sto_latency got %0d want 1024..1026", cyc); end
    vectors++; if (err_timeout !== 1'b1 || res_reject !== 1'b1) begin miscompares++; $display("[TB] FAIL sto_flags got err=%b rej=%b want 1,1", err_timeout, res_reject); end
    vectors++; if (res_suit !== 2'd0 || res_score !== 10'd1023) begin miscompares++; $display("[TB] FAIL sto_fields got suit=%0d score=%0d want 0,1023", res_suit, res_score); end
    release_result();
    run_job(11'd9, 10'd9, {10'd40, 10'd30, 10'd20, 10'd300}, ok, kok);
    @(negedge clk);
    vectors++; if (ok !== 1'b1 || res_valid !== 1'b1 || err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL sto_next_job got ok=%b valid=%b err=%b want 1,1,0", ok, res_valid, err_timeout); end
    vectors++; if (res_suit !== 2'd1 || res_score !== 10'd20 || res_margin !== 10'd10) begin miscompares++; $display("[TB] FAIL sto_next_fields got suit=%0d score=%0d margin=%0d want 1,20,10", res_suit, res_score, res_margin); end
    release_result();
  endtask

  task automatic test_capture_timeout();
    send_req(11'd11, 10'd12);
    frame_start();
    vectors++; if (scr_capture_arm !== 1'b1) begin miscompares++; $display("[TB] FAIL cto_arm got %b want 1", scr_capture_arm); end
    repeat (4) @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL cto_early got %b want 0", res_valid); end
    frame_start();
    vectors++; if (res_valid !== 1'b1 || err_timeout !== 1'b1 || res_reject !== 1'b1) begin miscompares++; $display("[TB] FAIL cto_abort got valid=%b err=%b rej=%b want 1,1,1", res_valid, err_timeout, res_reject); end
    vectors++; if (scr_capture_arm !== 1'b0 || res_suit !== 2'd0) begin miscompares++; $display("[TB] FAIL cto_fields got arm=%b suit=%0d want 0,0", scr_capture_arm, res_suit); end
    release_result();
  endtask

  task automatic test_reset_midjob();
    bit ok;
    send_req(11'd13, 10'd14);
    frame_start();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (scr_capture_arm !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_capture got arm=%b ready=%b want 0,1", scr_capture_arm, req_ready); end
    send_req(11'd13, 10'd14);
    frame_start();
    pulse_captured();
    wait_start(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (ok !== 1'b1 || req_ready !== 1'b1 || scr_capture_arm !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait_score got ok=%b ready=%b arm=%b want 1,1,0", ok, req_ready, scr_capture_arm); end
    vectors++; if (res_valid !== 1'b0 || scr_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait_score_out got valid=%b start=%b want 0,0", res_valid, scr_start); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok, kok;
    run_job(11'd100, 10'd50, {10'd40, 10'd30, 10'd20, 10'd10}, ok, kok);
    @(negedge clk);
    vectors++; if (ok !== 1'b1 || res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first got ok=%b valid=%b want 1,1", ok, res_valid); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++; if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_suit !== 2'd0 || res_score !== 10'd10 || res_margin !== 10'd10 || res_reject !== 1'b0 || err_timeout !== 1'b0) begin
        miscompares++; $display("[TB] FAIL b2b_hold cycle %0d got v=%b rdy=%b suit=%0d score=%0d margin=%0d rej=%b err=%b want 1,0,0,10,10,0,0", i, res_valid, req_ready, res_suit, res_score, res_margin, res_reject, err_timeout);
      end
    end
    release_result();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready got %b want 1", req_ready); end
    run_job(11'd300, 10'd200, {10'd610, 10'd650, 10'd600, 10'd700}, ok, kok);
    @(negedge clk);
    vectors++; if (ok !== 1'b1 || kok !== 1'b1 || res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second got ok=%b ksel=%b valid=%b want 1,1,1", ok, kok, res_valid); end
    vectors++; if (res_suit !== 2'd1 || res_score !== 10'd600 || res_margin !== 10'd10 || res_reject !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_fields got suit=%0d score=%0d margin=%0d rej=%b want 1,600,10,1", res_suit, res_score, res_margin, res_reject); end
    vectors++; if (scr_left_edge !== 11'd300 || scr_top_edge !== 10'd200) begin miscompares++; $display("[TB] FAIL b2b_edges got %0d,%0d want 300,200", scr_left_edge, scr_top_edge); end
    release_result();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    hcount        = 11'd5;
    vcount        = 10'd5;
    req_valid     = 1'b0;
    req_left_edge = '0;
    req_top_edge  = '0;
    scr_captured  = 1'b0;
    scr_done      = 1'b0;
    scr_score     = '0;
    res_ready     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tie();
    test_all_equal();
    test_score_timeout();
    test_capture_timeout();
    test_reset_midjob();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
